// File: rtl/multi_drive_resolver_if.sv
// rtl/multi_drive_resolver_if.sv - driver-sample and resolved-net bundle for multi_drive_resolver
//
// Groups the beat-level signals of the resolver.
//   in_valid     : driver sample beat
//   drv_code     : N_DRV x WIDTH 2-bit codes, driver d bit i at [(d*WIDTH+i)*2 +: 2]
//   clr_cnt      : synchronous clear of conflict_cnt
//   out_valid    : resolved beat, one cycle after in_valid
//   out_code     : resolved 4-state net, WIDTH 2-bit codes (00=0 01=1 10=Z 11=X)
//   conflict     : per-bit 0/1 contention of the last beat
//   conflict_cnt : saturating count of beats with any contention
// master = the source of driver samples, slave = the resolver.
interface multi_drive_resolver_if #(
    parameter int N_DRV = 4,
    parameter int WIDTH = 8
);
    logic                       in_valid;
    logic [N_DRV*WIDTH*2-1:0]   drv_code;
    logic                       clr_cnt;
    logic                       out_valid;
    logic [WIDTH*2-1:0]         out_code;
    logic [WIDTH-1:0]           conflict;
    logic [15:0]                conflict_cnt;

    modport master (
        output in_valid, drv_code, clr_cnt,
        input  out_valid, out_code, conflict, conflict_cnt
    );

    modport slave (
        input  in_valid, drv_code, clr_cnt,
        output out_valid, out_code, conflict, conflict_cnt
    );
endinterface

// File: rtl/multi_drive_resolver.sv
// rtl/multi_drive_resolver.sv - resolves N 4-state drivers per bit into one net with Verilog net semantics
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : multi_drive_resolver_if.slave (in_valid, drv_code, clr_cnt in;
//         out_valid, out_code, conflict, conflict_cnt out)
// MODE selects the net type: 0=wire 1=wor 2=wand 3=tri0 4=tri1 5=trireg.
// In trireg mode each bit holds its last driven value for DECAY undriven
// beats and then turns X; DECAY=0 keeps the charge forever.
module multi_drive_resolver #(
    parameter int N_DRV = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 1,
    parameter int DECAY = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_drive_resolver_if.slave bus
);
    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b01;
    localparam logic [1:0] VZ = 2'b10;
    localparam logic [1:0] VX = 2'b11;

    // Value of a bit that nobody drives; trireg starts discharged (X).
    localparam logic [1:0] UNDRV = (MODE == 3) ? V0 :
                                   (MODE == 4) ? V1 :
                                   (MODE == 5) ? VX : VZ;

    // Age must be able to hold DECAY+1, the saturation point.
    localparam int              AGE_W   = $clog2(DECAY + 2);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DECAY + 1);
    localparam logic [AGE_W-1:0] DECAY_V = AGE_W'(DECAY);

    if (N_DRV < 2 || N_DRV > 8 || WIDTH < 1 || WIDTH > 64 ||
        MODE < 0 || MODE > 5 || DECAY < 0) begin : g_bad_param
        $error("multi_drive_resolver: illegal N_DRV/WIDTH/MODE/DECAY");
    end

    logic                   out_valid_q;
    logic [WIDTH*2-1:0]     out_code_q;
    logic [WIDTH-1:0]       conflict_q;
    logic [15:0]            cnt_q;
    logic [WIDTH*2-1:0]     charge_q;
    logic [WIDTH*AGE_W-1:0] age_q;

    logic [WIDTH*2-1:0]     res_n;
    logic [WIDTH-1:0]       conf_n;
    logic [WIDTH*2-1:0]     charge_n;
    logic [WIDTH*AGE_W-1:0] age_n;
    logic                   has0, has1, hasx, driven;
    logic [1:0]             dval, bitres;
    logic [AGE_W-1:0]       age_cur, age_inc;

    always_comb begin
        res_n    = out_code_q;
        conf_n   = '0;
        charge_n = charge_q;
        age_n    = age_q;
        has0     = 1'b0;
        has1     = 1'b0;
        hasx     = 1'b0;
        driven   = 1'b0;
        dval     = VX;
        bitres   = VX;
        age_cur  = '0;
        age_inc  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            has0 = 1'b0;
            has1 = 1'b0;
            hasx = 1'b0;
            for (int d = 0; d < N_DRV; d++) begin
                case (bus.drv_code[(d*WIDTH+i)*2 +: 2])
                    V0:      has0 = 1'b1;
                    V1:      has1 = 1'b1;
                    VX:      hasx = 1'b1;
                    default: ;
                endcase
            end
            driven    = has0 | has1 | hasx;
            conf_n[i] = has0 & has1;

            // Resolution of the non-Z drivers; only used when driven.
            case (MODE)
                1:       dval = has1 ? V1 : (hasx ? VX : V0);
                2:       dval = has0 ? V0 : (hasx ? VX : V1);
                default: dval = (hasx || (has0 && has1)) ? VX : (has1 ? V1 : V0);
            endcase

            age_cur = age_q[i*AGE_W +: AGE_W];
            age_inc = (age_cur == AGE_MAX) ? AGE_MAX : age_cur + AGE_W'(1);

            if (driven) begin
                bitres = dval;
            end else if (MODE == 5) begin
                if (DECAY != 0 && age_inc > DECAY_V) bitres = VX;
                else                                 bitres = charge_q[i*2 +: 2];
            end else begin
                bitres = UNDRV;
            end

            res_n[i*2 +: 2]          = bitres;
            // A decayed charge becomes X, which is exactly bitres.
            charge_n[i*2 +: 2]       = bitres;
            age_n[i*AGE_W +: AGE_W]  = driven ? '0 : age_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_code_q  <= {WIDTH{UNDRV}};
            conflict_q  <= '0;
            cnt_q       <= '0;
            charge_q    <= {WIDTH{VX}};
            age_q       <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            // Charge and age only move on beats so idle cycles never decay.
            if (bus.in_valid) begin
                out_code_q <= res_n;
                conflict_q <= conf_n;
                charge_q   <= charge_n;
                age_q      <= age_n;
            end
            if (bus.clr_cnt)
                cnt_q <= '0;
            else if (bus.in_valid && (|conf_n) && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_code     = out_code_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_multi_drive_resolver.sv
// tb/tb_multi_drive_resolver.sv - self-checking bench for multi_drive_resolver across all six net modes
module tb_multi_drive_resolver;
    localparam int NM    = 6;
    localparam int ND    = 4;
    localparam int W     = 8;
    localparam int DECAY = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [ND*W*2-1:0] drv_code;
    logic            clr_cnt = 1'b0;

    logic [NM-1:0]        ov_a;
    logic [NM-1:0][15:0]  oc_a;
    logic [NM-1:0][7:0]   cf_a;
    logic [NM-1:0][15:0]  cn_a;

    always #5 clk = ~clk;

    for (genvar m = 0; m < NM; m++) begin : g_mode
        multi_drive_resolver_if #(.N_DRV(ND), .WIDTH(W)) bus ();
        assign bus.in_valid = in_valid;
        assign bus.drv_code = drv_code;
        assign bus.clr_cnt  = clr_cnt;
        multi_drive_resolver #(.N_DRV(ND), .WIDTH(W), .MODE(m), .DECAY(DECAY)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign ov_a[m] = bus.out_valid;
        assign oc_a[m] = bus.out_code;
        assign cf_a[m] = bus.conflict;
        assign cn_a[m] = bus.conflict_cnt;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic        exp_valid;
    logic [15:0] exp_code [NM];
    logic [7:0]  exp_conf;
    int          exp_cnt;
    logic [1:0]  tchg [W];
    int          tage [W];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Resolve a bit from how many drivers showed 0, 1 and X (Z ignored).
    function automatic logic [1:0] resolve(input int mode, input int n0, input int n1, input int nx);
        int nd = n0 + n1 + nx;
        if (nd == 0) begin
            if (mode == 3) return 2'b00;
            if (mode == 4) return 2'b01;
            return 2'b10;
        end
        if (mode == 1) return (n1 > 0) ? 2'b01 : ((nx > 0) ? 2'b11 : 2'b00);
        if (mode == 2) return (n0 > 0) ? 2'b00 : ((nx > 0) ? 2'b11 : 2'b01);
        if (n0 == nd) return 2'b00;
        if (n1 == nd) return 2'b01;
        return 2'b11;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_conf  = '0;
        exp_cnt   = 0;
        exp_code[0] = {W{2'b10}};
        exp_code[1] = {W{2'b10}};
        exp_code[2] = {W{2'b10}};
        exp_code[3] = {W{2'b00}};
        exp_code[4] = {W{2'b01}};
        exp_code[5] = {W{2'b11}};
        for (int i = 0; i < W; i++) begin
            tchg[i] = 2'b11;
            tage[i] = 0;
        end
    endtask

    task automatic model_update();
        logic anyc;
        int n0, n1, nx;
        logic [1:0] f;
        anyc = 1'b0;
        exp_valid = in_valid;
        if (in_valid) begin
            for (int i = 0; i < W; i++) begin
                n0 = 0; n1 = 0; nx = 0;
                for (int d = 0; d < ND; d++) begin
                    f = drv_code[(d*W+i)*2 +: 2];
                    if (f == 2'b00) n0++;
                    else if (f == 2'b01) n1++;
                    else if (f == 2'b11) nx++;
                end
                exp_conf[i] = (n0 > 0 && n1 > 0);
                if (exp_conf[i]) anyc = 1'b1;
                for (int m = 0; m < 5; m++) exp_code[m][i*2 +: 2] = resolve(m, n0, n1, nx);
                if (n0 + n1 + nx > 0) begin
                    tchg[i] = resolve(0, n0, n1, nx);
                    tage[i] = 0;
                end else begin
                    tage[i] = (tage[i] + 1 > DECAY + 1) ? DECAY + 1 : tage[i] + 1;
                    if (tage[i] > DECAY) tchg[i] = 2'b11;
                end
                exp_code[5][i*2 +: 2] = tchg[i];
            end
        end
        if (clr_cnt) exp_cnt = 0;
        else if (in_valid && anyc && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic check_all(input string where);
        for (int m = 0; m < NM; m++) begin
            chk($sformatf("%s_m%0d_valid", where, m), 64'(ov_a[m]), 64'(exp_valid));
            chk($sformatf("%s_m%0d_code", where, m), 64'(oc_a[m]), 64'(exp_code[m]));
            chk($sformatf("%s_m%0d_conf", where, m), 64'(cf_a[m]), 64'(exp_conf));
            chk($sformatf("%s_m%0d_cnt", where, m), 64'(cn_a[m]), 64'(exp_cnt));
        end
    endtask

    task automatic step(input string where, input bit check);
        @(posedge clk);
        #1;
        model_update();
        if (check) check_all(where);
    endtask

    task automatic all_z();
        drv_code = {ND*W{2'b10}};
    endtask

    task automatic set_drv(input int d, input int i, input logic [1:0] c);
        drv_code[(d*W+i)*2 +: 2] = c;
    endtask

    initial begin
        all_z();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Wire: bit0 {0,1,Z,Z}
        in_valid = 1'b1;
        all_z();
        set_drv(0, 0, 2'b00);
        set_drv(1, 0, 2'b01);
        step("wire_mix", 1);
        chk("wire_mix_code0", 64'(oc_a[0][1:0]), 64'h3);
        chk("wire_mix_conf0", 64'(cf_a[0][0]), 64'h1);
        chk("wire_mix_cnt", 64'(cn_a[0]), 64'h1);

        // Wor: {X,1,Z,0} then {X,0,Z,Z}
        all_z();
        set_drv(0, 0, 2'b11); set_drv(1, 0, 2'b01); set_drv(3, 0, 2'b00);
        step("wor_a", 1);
        chk("wor_a_code0", 64'(oc_a[1][1:0]), 64'h1);
        chk("wor_a_conf0", 64'(cf_a[1][0]), 64'h1);
        all_z();
        set_drv(0, 0, 2'b11); set_drv(1, 0, 2'b00);
        step("wor_b", 1);
        chk("wor_b_code0", 64'(oc_a[1][1:0]), 64'h3);
        chk("wor_b_conf0", 64'(cf_a[1][0]), 64'h0);

        // All Z: tri0/tri1 pulls, wire floats
        all_z();
        step("allz", 1);
        chk("tri0_allz", 64'(oc_a[3]), 64'h0000);
        chk("tri1_allz", 64'(oc_a[4]), 64'h5555);
        chk("wire_allz", 64'(oc_a[0]), 64'hAAAA);
        // Wand {1,1,Z,Z}
        for (int i = 0; i < W; i++) begin set_drv(0, i, 2'b01); set_drv(1, i, 2'b01); end
        step("wand11", 1);
        chk("wand11_code", 64'(oc_a[2]), 64'h5555);

        // Trireg decay with idle cycles interleaved
        all_z();
        for (int i = 0; i < W; i++) set_drv(2, i, 2'b01);
        step("treg_drive", 1);
        chk("treg_drive_code", 64'(oc_a[5]), 64'h5555);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b0;
            step("treg_idle", 1);
            in_valid = 1'b1;
            all_z();
            step("treg_z", 1);
        end
        chk("treg_decayed", 64'(oc_a[5]), 64'hFFFF);

        // Randomized beats with idle gaps and occasional clears
        for (int c = 0; c < 400; c++) begin
            automatic bit zbeat = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            clr_cnt  = ($urandom_range(0, 19) == 0);
            for (int d = 0; d < ND; d++)
                for (int i = 0; i < W; i++) begin
                    automatic int r = $urandom_range(0, 5);
                    set_drv(d, i, zbeat ? 2'b10 : (r < 3) ? 2'b10 : (r == 3) ? 2'b00 : (r == 4) ? 2'b01 : 2'b11);
                end
            step("rand", 1);
        end
        clr_cnt = 1'b0;

        // Saturation of the conflict counter
        in_valid = 1'b1;
        all_z();
        set_drv(0, 0, 2'b00);
        set_drv(1, 0, 2'b01);
        for (int c = 0; c < 65540; c++) step("sat", 0);
        check_all("sat");
        chk("sat_cnt", 64'(cn_a[0]), 64'hFFFF);
        clr_cnt = 1'b1;
        step("clr_vs_inc", 1);
        chk("clr_vs_inc_cnt", 64'(cn_a[0]), 64'h0);
        clr_cnt = 1'b0;

        // Asynchronous reset mid-stream with a beat pending
        in_valid = 1'b1;
        for (int i = 0; i < W; i++) set_drv(2, i, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        step("post_rst", 1);
        chk("post_rst_valid", 64'(ov_a[0]), 64'h0);
        in_valid = 1'b1;
        step("post_rst_beat", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
